serial_ha_adder: RTL

SERIAL_HA_ADDER -- requirements
Module: serial_ha_adder

---
 rtl/serial_ha_adder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/serial_ha_adder.sv
// Bit-serial adder, LSB first. Two half-adder stages and a carry flop process
// one bit per clock. The result is published on sum/cout only when complete.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// SHIFT | one operand bit pair consumed per clock
// DONE  | one-cycle pulse, sum/cout newly valid
module serial_ha_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_next;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             last_bit;

    logic ha0_s;
    logic ha0_c;
    logic ha1_s;
    logic ha1_c;
    logic carry_next;

    // Two half-adder stages: operand bits first, then the running carry.
    always_comb begin
        ha0_s      = a_q[0] ^ b_q[0];
        ha0_c      = a_q[0] & b_q[0];
        ha1_s      = ha0_s ^ carry_q;
        ha1_c      = ha0_s & carry_q;
        carry_next = ha0_c | ha1_c;
        res_next   = {ha1_s, res_q[WIDTH-1:1]};
        last_bit   = (cnt_q == CW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and status decodes; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, serial shift and result publication.
    // The counter holds on the final bit so it never wraps mid-operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        res_q   <= '0;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_next;
                    carry_q <= carry_next;
                    if (last_bit) begin
                        sum  <= res_next;
                        cout <= carry_next;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
